// File: rtl/psum_wb_pkg.sv
// rtl/psum_wb_pkg.sv - shared state encoding for the PSUM writeback controller
package psum_wb_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        ACC_RD = 3'd2,
        ACC_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/psum_lane_adder.sv
// rtl/psum_lane_adder.sv - col independent psum_bw-bit wrapping adders
module psum_lane_adder #(
    parameter int col     = 8,
    parameter int psum_bw = 16
) (
    input  logic [psum_bw*col-1:0] a,
    input  logic [psum_bw*col-1:0] b,
    output logic [psum_bw*col-1:0] sum
);

    // Each lane is sliced separately so no carry ever crosses a lane boundary.
    for (genvar i = 0; i < col; i++) begin : g_lane
        assign sum[i*psum_bw +: psum_bw] = a[i*psum_bw +: psum_bw] + b[i*psum_bw +: psum_bw];
    end

endmodule

// File: rtl/psum_writeback.sv
// rtl/psum_writeback.sv - OFIFO drain and PSUM SRAM writeback controller
// Optional read-modify-write accumulation is compiled in with PSUM_ACC_EN.
module psum_writeback
    import psum_wb_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int ADDR_W  = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W-1:0]      num_rows,
`ifdef PSUM_ACC_EN
    input  logic                   accumulate,
`endif
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic [ADDR_W-1:0]      psum_mem_addr,
    output logic                   psum_mem_rd,
    output logic                   psum_mem_wr,
    output logic [psum_bw*col-1:0] psum_mem_din,
    input  logic [psum_bw*col-1:0] psum_mem_dout,
    output logic                   busy,
    output logic                   done
);

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W-1:0]   rows_r;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   cur_addr;
    logic                last_row;
    logic                step;

    assign cur_addr = base_r + idx;
    assign last_row = (idx == rows_r - 1'b1);
    assign step     = ((state == STREAM) && ofifo_valid) || (state == ACC_WR);

`ifdef PSUM_ACC_EN
    logic [psum_bw*col-1:0] hold;
    logic [psum_bw*col-1:0] acc_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold <= '0;
        end else if ((state == ACC_RD) && ofifo_valid) begin
            hold <= ofifo_out;
        end
    end

    psum_lane_adder #(
        .col     (col),
        .psum_bw (psum_bw)
    ) u_lane_adder (
        .a   (psum_mem_dout),
        .b   (hold),
        .sum (acc_sum)
    );
`else
    logic unused_dout;
    assign unused_dout = ^psum_mem_dout;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_r <= '0;
            rows_r <= '0;
            idx    <= '0;
        end else if ((state == IDLE) && start) begin
            base_r <= base_addr;
            rows_r <= num_rows;
            idx    <= '0;
        end else if (step) begin
            idx <= idx + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_rows == '0) begin
                        next_state = DONE;
`ifdef PSUM_ACC_EN
                    end else if (accumulate) begin
                        next_state = ACC_RD;
`endif
                    end else begin
                        next_state = STREAM;
                    end
                end
            end
            STREAM: if (ofifo_valid && last_row) next_state = DONE;
`ifdef PSUM_ACC_EN
            ACC_RD: if (ofifo_valid) next_state = ACC_WR;
            ACC_WR: next_state = last_row ? DONE : ACC_RD;
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory strobes and data stay 0 whenever no access is being made.
    always_comb begin
        ofifo_rd      = 1'b0;
        psum_mem_rd   = 1'b0;
        psum_mem_wr   = 1'b0;
        psum_mem_addr = '0;
        psum_mem_din  = '0;
        case (state)
            STREAM: begin
                if (ofifo_valid) begin
                    ofifo_rd      = 1'b1;
                    psum_mem_wr   = 1'b1;
                    psum_mem_addr = cur_addr;
                    psum_mem_din  = ofifo_out;
                end
            end
`ifdef PSUM_ACC_EN
            ACC_RD: begin
                if (ofifo_valid) begin
                    ofifo_rd      = 1'b1;
                    psum_mem_rd   = 1'b1;
                    psum_mem_addr = cur_addr;
                end
            end
            ACC_WR: begin
                psum_mem_wr   = 1'b1;
                psum_mem_addr = cur_addr;
                psum_mem_din  = acc_sum;
            end
`endif
            default: ;
        endcase
    end

    assign busy = (state == STREAM) || (state == ACC_RD) || (state == ACC_WR);
    assign done = (state == DONE);

endmodule

// File: tb/tb_psum_writeback.sv
// tb/tb_psum_writeback.sv - directed self-checking bench for psum_writeback
module tb_psum_writeback;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 11;
    localparam int VW  = COL * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_rows = '0;
`ifdef PSUM_ACC_EN
    logic          accumulate = 1'b0;
`endif
    logic          ofifo_valid;
    logic [VW-1:0] ofifo_out;
    logic          ofifo_rd;
    logic [AW-1:0] psum_mem_addr;
    logic          psum_mem_rd;
    logic          psum_mem_wr;
    logic [VW-1:0] psum_mem_din;
    logic [VW-1:0] psum_mem_dout = '0;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;

    logic [VW-1:0] fifo_mem [0:15];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          valid_en = 1'b0;

    logic [VW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] wlog_addr [0:63];
    logic [VW-1:0] wlog_data [0:63];
    int            wlog_cyc  [0:63];
    int            wcount = 0;
    int            rcount = 0;
    int            both_count = 0;
    int            done_count = 0;
    int            done_cyc = 0;
    int            cyc = 0;

    always #5 clk = ~clk;

    assign ofifo_valid = valid_en && (rd_ptr != wr_ptr);
    assign ofifo_out   = fifo_mem[rd_ptr[3:0]];

    // OFIFO pop, SRAM model and activity log
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ofifo_rd) rd_ptr <= rd_ptr + 1;
        if (psum_mem_wr) begin
            mem[psum_mem_addr]        <= psum_mem_din;
            wlog_addr[wcount[5:0]]    <= psum_mem_addr;
            wlog_data[wcount[5:0]]    <= psum_mem_din;
            wlog_cyc[wcount[5:0]]     <= cyc;
            wcount                    <= wcount + 1;
        end
        if (psum_mem_rd) begin
            psum_mem_dout <= mem[psum_mem_addr];
            rcount        <= rcount + 1;
        end
        if (psum_mem_rd && psum_mem_wr) both_count <= both_count + 1;
        if (done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
    end

    psum_writeback #(
        .col     (COL),
        .psum_bw (BW),
        .ADDR_W  (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .num_rows      (num_rows),
`ifdef PSUM_ACC_EN
        .accumulate    (accumulate),
`endif
        .ofifo_valid   (ofifo_valid),
        .ofifo_out     (ofifo_out),
        .ofifo_rd      (ofifo_rd),
        .psum_mem_addr (psum_mem_addr),
        .psum_mem_rd   (psum_mem_rd),
        .psum_mem_wr   (psum_mem_wr),
        .psum_mem_din  (psum_mem_din),
        .psum_mem_dout (psum_mem_dout),
        .busy          (busy),
        .done          (done)
    );

    function automatic logic [VW-1:0] make_vec(input logic [15:0] b);
        logic [VW-1:0] v;
        for (int i = 0; i < COL; i++) v[i*BW +: BW] = b + 16'(i);
        return v;
    endfunction

    function automatic logic [VW-1:0] fill(input logic [15:0] b);
        logic [VW-1:0] v;
        for (int i = 0; i < COL; i++) v[i*BW +: BW] = b;
        return v;
    endfunction

    task automatic push(input logic [VW-1:0] v);
        fifo_mem[wr_ptr[3:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    task automatic start_pass(input logic [AW-1:0] b, input logic [AW-1:0] n, output int s);
        s = cyc;
        base_addr = b;
        num_rows  = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        push(make_vec(16'h0abc));
        valid_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (ofifo_rd !== 1'b0) begin bad++; $display("FAIL reset_ofifo_rd: got %b want 0", ofifo_rd); end
        total++; if (psum_mem_wr !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b want 0", psum_mem_wr); end
        total++; if (psum_mem_rd !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b want 0", psum_mem_rd); end
        total++; if (psum_mem_addr !== 11'h000) begin bad++; $display("FAIL reset_addr: got %h want 000", psum_mem_addr); end
        total++; if (psum_mem_din !== '0) begin bad++; $display("FAIL reset_din: got %h want 0", psum_mem_din); end
        @(posedge clk);
        #1;
        flush();
    endtask

    task automatic test_plain_drain();
        int s, w0, r0, d0;
        bit ok;
        logic [VW-1:0] v [4];
        flush();
        for (int k = 0; k < 4; k++) begin
            v[k] = make_vec(16'(16'h1000 * (k + 1)));
            push(v[k]);
        end
        valid_en = 1'b1;
        w0 = wcount; r0 = rcount; d0 = done_count;
        start_pass(11'h010, 11'd4, s);
        wait_done(20, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL drain_done_seen: got %b want 1", ok); end
        @(posedge clk);
        #1;
        total++; if (wcount - w0 !== 4) begin bad++; $display("FAIL drain_wcount: got %0d want 4", wcount - w0); end
        for (int k = 0; k < 4; k++) begin
            total++; if (wlog_addr[w0+k] !== 11'(16 + k)) begin bad++; $display("FAIL drain_addr%0d: got %h want %h", k, wlog_addr[w0+k], 11'(16 + k)); end
            total++; if (wlog_data[w0+k] !== v[k]) begin bad++; $display("FAIL drain_data%0d: got %h want %h", k, wlog_data[w0+k], v[k]); end
            total++; if (wlog_cyc[w0+k] !== s + 1 + k) begin bad++; $display("FAIL drain_cycle%0d: got %0d want %0d", k, wlog_cyc[w0+k], s + 1 + k); end
        end
        total++; if (done_cyc !== s + 5) begin bad++; $display("FAIL drain_done_cycle: got %0d want %0d", done_cyc, s + 5); end
        total++; if (done_count - d0 !== 1) begin bad++; $display("FAIL drain_done_pulses: got %0d want 1", done_count - d0); end
        total++; if (rcount - r0 !== 0) begin bad++; $display("FAIL drain_no_reads: got %0d want 0", rcount - r0); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL drain_idle: got busy=%b done=%b want 0 0", busy, done); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int s, w0;
        bit ok;
        logic [4:0] pat;
        pat = 5'b11001;
        flush();
        for (int k = 0; k < 3; k++) push(make_vec(16'(16'h2000 + 16'h100 * k)));
        valid_en = 1'b0;
        w0 = wcount;
        start_pass(11'h100, 11'd3, s);
        for (int k = 0; k < 5; k++) begin
            valid_en = pat[k];
            @(negedge clk);
            total++; if (ofifo_rd !== pat[k]) begin bad++; $display("FAIL stall_rd_c%0d: got %b want %b", k, ofifo_rd, pat[k]); end
            total++; if (psum_mem_wr !== pat[k]) begin bad++; $display("FAIL stall_wr_c%0d: got %b want %b", k, psum_mem_wr, pat[k]); end
            @(posedge clk);
            #1;
        end
        wait_done(4, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_done_seen: got %b want 1", ok); end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (wlog_addr[w0+k] !== 11'(256 + k)) begin bad++; $display("FAIL stall_addr%0d: got %h want %h", k, wlog_addr[w0+k], 11'(256 + k)); end
            total++; if (wlog_data[w0+k] !== make_vec(16'(16'h2000 + 16'h100 * k))) begin bad++; $display("FAIL stall_data%0d: got %h", k, wlog_data[w0+k]); end
        end
    endtask

    task automatic test_addr_wrap();
        int s, w0;
        bit ok;
        flush();
        push(make_vec(16'h3000));
        push(make_vec(16'h3100));
        valid_en = 1'b1;
        w0 = wcount;
        start_pass(11'h7ff, 11'd2, s);
        wait_done(10, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_done_seen: got %b want 1", ok); end
        @(posedge clk);
        #1;
        total++; if (wlog_addr[w0] !== 11'h7ff) begin bad++; $display("FAIL wrap_addr0: got %h want 7ff", wlog_addr[w0]); end
        total++; if (wlog_addr[w0+1] !== 11'h000) begin bad++; $display("FAIL wrap_addr1: got %h want 000", wlog_addr[w0+1]); end
    endtask

    task automatic test_zero_rows();
        int s, w0, r0, p0, d0;
        flush();
        push(make_vec(16'h4000));
        valid_en = 1'b1;
        w0 = wcount; r0 = rcount; p0 = rd_ptr; d0 = done_count;
        start_pass(11'h055, 11'd0, s);
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy); end
        total++; if (ofifo_rd !== 1'b0 || psum_mem_wr !== 1'b0) begin bad++; $display("FAIL zero_access: got rd=%b wr=%b want 0 0", ofifo_rd, psum_mem_wr); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (wcount - w0 + rcount - r0 !== 0) begin bad++; $display("FAIL zero_mem_ops: got %0d want 0", wcount - w0 + rcount - r0); end
        total++; if (rd_ptr - p0 !== 0) begin bad++; $display("FAIL zero_pops: got %0d want 0", rd_ptr - p0); end
        total++; if (done_count - d0 !== 1 || done_cyc !== s + 1) begin bad++; $display("FAIL zero_done_cycle: got %0d pulses at %0d want 1 at %0d", done_count - d0, done_cyc, s + 1); end
    endtask

    task automatic test_abort();
        int s, w0, d0, p0;
        flush();
        for (int k = 0; k < 4; k++) push(make_vec(16'(16'h5000 + k)));
        valid_en = 1'b1;
        w0 = wcount; d0 = done_count; p0 = rd_ptr;
        start_pass(11'h060, 11'd4, s);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        total++; if (ofifo_rd !== 1'b0 || psum_mem_wr !== 1'b0) begin bad++; $display("FAIL abort_strobes: got rd=%b wr=%b want 0 0", ofifo_rd, psum_mem_wr); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_status: got busy=%b done=%b want 0 0", busy, done); end
        total++; if (psum_mem_addr !== 11'h000) begin bad++; $display("FAIL abort_addr: got %h want 000", psum_mem_addr); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (wcount - w0 !== 2) begin bad++; $display("FAIL abort_writes: got %0d want 2", wcount - w0); end
        total++; if (rd_ptr - p0 !== 2) begin bad++; $display("FAIL abort_pops: got %0d want 2", rd_ptr - p0); end
        total++; if (done_count - d0 !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", done_count - d0); end
        flush();
    endtask

    task automatic test_ignored_start();
        int s, w0, d0;
        bit ok;
        flush();
        for (int k = 0; k < 4; k++) push(make_vec(16'(16'h6000 + 16'h10 * k)));
        valid_en = 1'b0;
        w0 = wcount; d0 = done_count;
        start_pass(11'h040, 11'd3, s);
        base_addr = 11'h100;
        num_rows  = 11'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy: got %b want 1", busy); end
        #1;
        valid_en = 1'b1;
        wait_done(10, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ign_done_seen: got %b want 1", ok); end
        base_addr = 11'h200;
        num_rows  = 11'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL ign_done_start: got busy=%b done=%b want 0 0", busy, done); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (wcount - w0 !== 3) begin bad++; $display("FAIL ign_wcount: got %0d want 3", wcount - w0); end
        for (int k = 0; k < 3; k++) begin
            total++; if (wlog_addr[w0+k] !== 11'(64 + k)) begin bad++; $display("FAIL ign_addr%0d: got %h want %h", k, wlog_addr[w0+k], 11'(64 + k)); end
        end
        total++; if (done_count - d0 !== 1) begin bad++; $display("FAIL ign_done_pulses: got %0d want 1", done_count - d0); end
        flush();
    endtask

`ifdef PSUM_ACC_EN
    task automatic test_accumulate();
        int s, both0;
        bit ok;
        flush();
        valid_en = 1'b1;
        accumulate = 1'b0;
        push(fill(16'd5));
        start_pass(11'h020, 11'd1, s);
        wait_done(10, ok);
        @(posedge clk);
        #1;
        push(fill(16'd3));
        both0 = both_count;
        accumulate = 1'b1;
        start_pass(11'h020, 11'd1, s);
        accumulate = 1'b0;
        @(negedge clk);
        total++; if (psum_mem_rd !== 1'b1 || psum_mem_wr !== 1'b0) begin bad++; $display("FAIL acc_rd_phase: got rd=%b wr=%b want 1 0", psum_mem_rd, psum_mem_wr); end
        total++; if (psum_mem_addr !== 11'h020 || ofifo_rd !== 1'b1) begin bad++; $display("FAIL acc_rd_addr: got %h pop=%b want 020 1", psum_mem_addr, ofifo_rd); end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (psum_mem_wr !== 1'b1 || psum_mem_rd !== 1'b0) begin bad++; $display("FAIL acc_wr_phase: got wr=%b rd=%b want 1 0", psum_mem_wr, psum_mem_rd); end
        total++; if (psum_mem_addr !== 11'h020 || ofifo_rd !== 1'b0) begin bad++; $display("FAIL acc_wr_addr: got %h pop=%b want 020 0", psum_mem_addr, ofifo_rd); end
        total++; if (psum_mem_din !== fill(16'd8)) begin bad++; $display("FAIL acc_sum: got %h want %h", psum_mem_din, fill(16'd8)); end
        wait_done(4, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL acc_done_seen: got %b want 1", ok); end
        @(posedge clk);
        #1;
        total++; if (done_cyc !== s + 3) begin bad++; $display("FAIL acc_done_cycle: got %0d want %0d", done_cyc, s + 3); end
        total++; if (both_count !== both0) begin bad++; $display("FAIL acc_overlap: got %0d want %0d", both_count, both0); end
    endtask

    task automatic test_lane_wrap();
        int s;
        bit ok;
        logic [VW-1:0] pre, add, want;
        pre  = fill(16'h0100);
        add  = fill(16'h0000);
        want = fill(16'h0100);
        pre[0*BW +: BW] = 16'h7fff;  add[0*BW +: BW] = 16'h0001;  want[0*BW +: BW] = 16'h8000;
        pre[1*BW +: BW] = 16'h1234;  add[1*BW +: BW] = 16'h0002;  want[1*BW +: BW] = 16'h1236;
        pre[2*BW +: BW] = 16'hffff;  add[2*BW +: BW] = 16'h0001;  want[2*BW +: BW] = 16'h0000;
        flush();
        valid_en = 1'b1;
        push(pre);
        start_pass(11'h030, 11'd1, s);
        wait_done(10, ok);
        @(posedge clk);
        #1;
        push(add);
        accumulate = 1'b1;
        start_pass(11'h030, 11'd1, s);
        accumulate = 1'b0;
        wait_done(10, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_acc_done: got %b want 1", ok); end
        @(posedge clk);
        #1;
        total++; if (mem[11'h030] !== want) begin bad++; $display("FAIL lane_wrap: got %h want %h", mem[11'h030], want); end
    endtask
`endif

    initial begin
        test_reset();
        test_plain_drain();
        test_stall();
        test_addr_wrap();
        test_zero_rows();
        test_abort();
        test_ignored_start();
`ifdef PSUM_ACC_EN
        test_accumulate();
        test_lane_wrap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_writeback.md
# psum_writeback

OFIFO drain and PSUM SRAM writeback controller: the consumer end of the corelet output path. It pops column vectors from the corelet OFIFO via `ofifo_rd`/`ofifo_valid` and writes them to consecutive PSUM SRAM addresses. When `PSUM_ACC_EN` is compiled in, it can instead read-modify-write, adding each vector to the value already stored. It sits beside the corelet and owns the PSUM memory port during a writeback pass.

## Interface
- `col`, default 8: lanes per OFIFO vector.
- `psum_bw`, default 16: bits per lane, two's complement.
- `ADDR_W`, default 11: PSUM SRAM address width.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: begins a pass; sampled only in IDLE.
- `base_addr`, in, ADDR_W: first SRAM address, latched on start.
- `num_rows`, in, ADDR_W: vectors to drain, latched on start.
- `accumulate`, in, 1: latched on start; 1 selects read-modify-write. Present only with `PSUM_ACC_EN`.
- `ofifo_valid`, in, 1: the OFIFO holds data; `ofifo_out` is show-ahead.
- `ofifo_out`, in, psum_bw*col: OFIFO head vector.
- `ofifo_rd`, out, 1: pops the head at the clock edge.
- `psum_mem_addr`, out, ADDR_W: SRAM address.
- `psum_mem_rd`, out, 1: SRAM read; `psum_mem_dout` is valid the next cycle.
- `psum_mem_wr`, out, 1: SRAM write.
- `psum_mem_din`, out, psum_bw*col: SRAM write data.
- `psum_mem_dout`, in, psum_bw*col: SRAM read data.
- `busy`, out, 1: a pass is in progress.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- **FSM states:** IDLE, STREAM, ACC_RD, ACC_WR, DONE.
- **IDLE:**
  - `start`=1 latches `base_addr`, `num_rows` and `accumulate`, and clears row counter `idx`.
  - Next state: DONE if `num_rows`==0; otherwise ACC_RD if `accumulate`=1; otherwise STREAM.
- **STREAM (plain write):**
  - When `ofifo_valid`=1 in the same cycle, assert `ofifo_rd`=1 and `psum_mem_wr`=1, with `psum_mem_addr`=base+idx and `psum_mem_din`=`ofifo_out`; `idx` then increments.
  - Throughput is one vector per cycle.
  - Move to DONE after the write with `idx`==`num_rows`-1.
- **ACC_RD:**
  - When `ofifo_valid`=1, assert `ofifo_rd`=1 and `psum_mem_rd`=1 at base+idx, capture `ofifo_out` into `hold`, then go to ACC_WR.
- **ACC_WR:**
  - `psum_mem_wr`=1 at the same address.
  - `psum_mem_din` lane i = `psum_mem_dout` lane i + `hold` lane i, modulo 2^psum_bw: wrap, no saturation, no carry between lanes.
  - `idx` increments. Next state is ACC_RD, or DONE after the last row.
  - Throughput is one vector per two cycles. Read and write are never asserted together (single-port SRAM).
- **Address:** base+idx wraps modulo 2^ADDR_W.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Stall:** with `ofifo_valid`=0, the FSM holds state and `ofifo_rd`, `psum_mem_rd` and `psum_mem_wr` are all 0. ACC_WR never stalls.
- **Ignored start:** `start` outside IDLE has no effect, including the DONE cycle.

## Timing
- **Reset values:** all outputs 0, state IDLE, `idx`=0, `hold`=0. Reset mid-pass aborts immediately: no further pops or writes, and `done` does not pulse.
- **Registered outputs:** `busy` and `done` are decoded from the state register. `busy` is high in STREAM, ACC_RD and ACC_WR.
- **Combinational outputs:** `ofifo_rd`, `psum_mem_rd`, `psum_mem_wr`, `psum_mem_addr` and `psum_mem_din` are combinational from the state, `idx`, `ofifo_valid` and the data inputs. They are 0 when inactive.
- **Start latency:** `start` sampled at edge N puts the FSM in STREAM/ACC_RD during cycle N+1. The first pop is possible in that cycle.
- **Completion:** the final write in cycle L gives `done` in cycle L+1 and IDLE in cycle L+2.
- **Zero rows:** with `num_rows`=0, `done` is asserted in cycle N+1 and no memory access occurs.

## Configuration
- `PSUM_ACC_EN` defined:
  - The `accumulate` port, the ACC_RD/ACC_WR states, the `hold` register and the lane adders exist.
  - `psum_mem_rd` is driven as described in Operation.
- `PSUM_ACC_EN` undefined:
  - No `accumulate` port; every pass is STREAM.
  - `psum_mem_rd` is tied to 0.

## Structure
- **Package `psum_wb_pkg`:** the state enum typedef (IDLE, STREAM, ACC_RD, ACC_WR, DONE) and the state-width constant.
- **Sub-module `psum_lane_adder`:** `col` parallel psum_bw-bit wrapping adders. Instantiated only under `PSUM_ACC_EN`.

## Test plan
- **Plain drain:** base=0x010, num_rows=4, OFIFO preloaded with 4 vectors → writes to 0x010–0x013 in 4 consecutive cycles, `done` one cycle after the last write, `psum_mem_rd` never 1.
- **Stall:** `ofifo_valid` toggles 1,0,0,1 → no `ofifo_rd`/`psum_mem_wr` while valid=0, and address order is preserved.
- **Accumulate:** SRAM[0x020] lanes = 5, OFIFO lanes = 3, accumulate=1 → read, then write of 8 on the next cycle; read and write never overlap.
- **Lane wrap:** lane 0x7FFF + 0x0001 → 0x8000, with neighbouring lanes unaffected.
- **Address and zero-row edges:** base=0x7FF, num_rows=2 → writes to 0x7FF then 0x000. num_rows=0 → `done` in cycle N+1 with no accesses.
- **Abort and ignored start:** reset asserted mid-pass → all outputs 0 at once and no `done`. `start` pulsed while `busy` → ignored.
